// File: rtl/router_pkg.sv
// Shared router constants and the FIFO word layout (header flag above the data byte).
package router_pkg;

    localparam int unsigned ROUTER_WIDTH      = 8;
    localparam int unsigned ROUTER_FIFO_DEPTH = 16;
    localparam int unsigned ROUTER_TIMEOUT    = 30;

    typedef struct packed {
        logic                    hdr;
        logic [ROUTER_WIDTH-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/router_rd_wdog.sv
// Reader-timeout watchdog: counts consecutive cycles with a valid byte left unread and
// fires a flush request plus a one-cycle registered soft_reset pulse on expiry.
module router_rd_wdog import router_pkg::*; #(
    parameter int unsigned TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic read_enb,
    output logic expire,
    output logic soft_reset
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          soft_reset_q;
    logic          idle;

    // Expiry is detected one count early so the flush lands on the edge that would reach TIMEOUT.
    always_comb begin
        idle     = vld && !read_enb;
        expire   = idle && (wd_cnt_q == LAST);
        wd_cnt_d = '0;
        if (idle && !expire) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_q     <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            wd_cnt_q     <= wd_cnt_d;
            soft_reset_q <= expire;
        end
    end

    assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_rd_port.sv
// Router output port: header-tagged byte FIFO with registered read data, packet-length
// tracking and a reader-timeout watchdog that flushes the port.
module router_rd_port import router_pkg::*; #(
    parameter int unsigned DEPTH   = ROUTER_FIFO_DEPTH,
    parameter int unsigned WIDTH   = ROUTER_WIDTH,
    parameter int unsigned TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enb,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lfd_state,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             full,
    output logic             empty,
    output logic             soft_reset
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-2:0] pkt_cnt_q;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH:0]   rd_word;
    logic             flush, wr_acc, rd_acc;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign vld_out  = ~empty;
    assign data_out = data_out_q;
    assign rd_word  = mem[rd_ptr_q];

    // Flush wins over a same-cycle write; flush implies !read_enb so reads never collide.
    assign wr_acc = write_enb && !full && !flush;
    assign rd_acc = read_enb && !empty;

    router_rd_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out),
        .read_enb   (read_enb),
        .expire     (flush),
        .soft_reset (soft_reset)
    );

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                data_out_q <= rd_word[WIDTH-1:0];
                // Header byte carries payload length in its upper bits; +1 counts parity.
                if (rd_word[WIDTH]) begin
                    pkt_cnt_q <= {1'b0, rd_word[WIDTH-1:2]} + (WIDTH - 1)'(1);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_q <= pkt_cnt_q - (WIDTH - 1)'(1);
                end
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_router_rd_port.sv
// Randomised and directed bench for router_rd_port against a queue-based behavioural model.
module tb_router_rd_port;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       write_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lfd_state = 1'b0;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       vld_out, full, empty, soft_reset;

    int nchk = 0;
    int nerr = 0;

    // Behavioural model: FIFO as a queue of {flag, byte}
    logic [8:0] q[$];
    logic [7:0] m_dout;
    int         m_pkt;
    int         m_wd;
    logic       m_soft;

    router_rd_port dut (
        .clock      (clock),
        .resetn     (resetn),
        .write_enb  (write_enb),
        .data_in    (data_in),
        .lfd_state  (lfd_state),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .vld_out    (vld_out),
        .full       (full),
        .empty      (empty),
        .soft_reset (soft_reset)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL sim_timeout: simulation ran out of time budget");
        $fatal(1);
    end

    function automatic void model_reset();
        q.delete();
        m_dout = 8'h00;
        m_pkt  = 0;
        m_wd   = 0;
        m_soft = 1'b0;
    endfunction

    // Apply one rising edge to the model using the inputs currently driven.
    function automatic void model_edge();
        bit         was_full, was_empty, idle;
        logic [8:0] w;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        idle      = !was_empty && !read_enb;
        m_soft    = idle && (m_wd + 1 == TIMEOUT);
        if (m_soft) begin
            q.delete();
            m_dout = 8'h00;
            m_pkt  = 0;
            m_wd   = 0;
        end else begin
            m_wd = idle ? m_wd + 1 : 0;
            if (read_enb && !was_empty) begin
                w      = q.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_pkt = int'(w[7:2]) + 1;
                else if (m_pkt > 0) m_pkt = m_pkt - 1;
            end
            if (write_enb && !was_full) q.push_back({lfd_state, data_in});
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        nchk++; if (data_out !== 8'h00) begin nerr++; $display("FAIL reset_dout: got %h want 00", data_out); end
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %b want 1", empty); end
        nchk++; if (full !== 1'b0) begin nerr++; $display("FAIL reset_full: got %b want 0", full); end
        nchk++; if (vld_out !== 1'b0) begin nerr++; $display("FAIL reset_vld: got %b want 0", vld_out); end
        nchk++; if (soft_reset !== 1'b0) begin nerr++; $display("FAIL reset_soft: got %b want 0", soft_reset); end
        @(posedge clock); #1;
        resetn = 1'b1;
        // Mid-packet reset
        for (int i = 0; i < 5; i++) begin
            write_enb = 1'b1; data_in = 8'($urandom); lfd_state = (i == 0); tick();
        end
        write_enb = 1'b0; lfd_state = 1'b0;
        read_enb = 1'b1; tick(); read_enb = 1'b0;
        #2 resetn = 1'b0;
        model_reset();
        #1;
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL midrst_empty: got %b want 1", empty); end
        nchk++; if (vld_out !== 1'b0) begin nerr++; $display("FAIL midrst_vld: got %b want 0", vld_out); end
        nchk++; if (data_out !== 8'h00) begin nerr++; $display("FAIL midrst_dout: got %h want 00", data_out); end
        nchk++; if (dut.pkt_cnt_q !== 7'd0) begin nerr++; $display("FAIL midrst_pkt: got %0d want 0", dut.pkt_cnt_q); end
        @(posedge clock); #1;
        resetn = 1'b1;
        write_enb = 1'b1; data_in = 8'hA5; tick(); write_enb = 1'b0;
        read_enb = 1'b1; tick(); read_enb = 1'b0;
        nchk++; if (data_out !== 8'hA5) begin nerr++; $display("FAIL postrst_read: got %h want a5", data_out); end
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL postrst_empty: got %b want 1", empty); end
    endtask

    task automatic test_packet();
        logic [7:0] bytes [5];
        int         pkts  [5];
        bytes = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h3F};
        pkts  = '{4, 3, 2, 1, 0};
        for (int i = 0; i < 5; i++) begin
            write_enb = 1'b1; data_in = bytes[i]; lfd_state = (i == 0); tick();
        end
        write_enb = 1'b0; lfd_state = 1'b0;
        read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            nchk++; if (data_out !== bytes[i]) begin nerr++; $display("FAIL pkt_data[%0d]: got %h want %h", i, data_out, bytes[i]); end
            nchk++; if (int'(dut.pkt_cnt_q) !== pkts[i]) begin nerr++; $display("FAIL pkt_cnt[%0d]: got %0d want %0d", i, dut.pkt_cnt_q, pkts[i]); end
        end
        read_enb = 1'b0;
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL pkt_empty: got %b want 1", empty); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 17; i++) begin
            write_enb = 1'b1; data_in = 8'(i); tick();
            if (i == 14) begin
                nchk++; if (full !== 1'b0) begin nerr++; $display("FAIL full_early: got %b want 0", full); end
            end
            if (i == 15) begin
                nchk++; if (full !== 1'b1) begin nerr++; $display("FAIL full_at16: got %b want 1", full); end
            end
        end
        write_enb = 1'b0;
        nchk++; if (dut.count_q !== 5'd16) begin nerr++; $display("FAIL full_drop: count %0d want 16", dut.count_q); end
        read_enb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            nchk++; if (data_out !== 8'(i)) begin nerr++; $display("FAIL full_read[%0d]: got %h want %h", i, data_out, 8'(i)); end
        end
        read_enb = 1'b0;
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL full_drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            write_enb = 1'b1; data_in = 8'h40 + 8'(i); tick();
        end
        for (int i = 0; i < 4; i++) begin
            write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h50 + 8'(i); tick();
            nchk++; if (dut.count_q !== 5'd8) begin nerr++; $display("FAIL simul_occ[%0d]: got %0d want 8", i, dut.count_q); end
            nchk++; if (data_out !== 8'h40 + 8'(i)) begin nerr++; $display("FAIL simul_data[%0d]: got %h want %h", i, data_out, 8'h40 + 8'(i)); end
        end
        read_enb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            write_enb = 1'b1; data_in = 8'h60 + 8'(i); tick();
        end
        nchk++; if (full !== 1'b1) begin nerr++; $display("FAIL simul_full: got %b want 1", full); end
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h77; tick();
        write_enb = 1'b0;
        nchk++; if (data_out !== 8'h44) begin nerr++; $display("FAIL simul_full_read: got %h want 44", data_out); end
        nchk++; if (dut.count_q !== 5'd15) begin nerr++; $display("FAIL simul_full_occ: got %0d want 15", dut.count_q); end
        nchk++; if (full !== 1'b0) begin nerr++; $display("FAIL simul_full_flag: got %b want 0", full); end
        for (int i = 0; i < 15; i++) begin
            tick();
            nchk++; if (data_out !== m_dout) begin nerr++; $display("FAIL simul_drain[%0d]: got %h want %h", i, data_out, m_dout); end
        end
        read_enb = 1'b0;
        nchk++; if (data_out !== 8'h67) begin nerr++; $display("FAIL simul_last: got %h want 67", data_out); end
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL simul_empty: got %b want 1", empty); end
    endtask

    task automatic test_watchdog();
        write_enb = 1'b1; data_in = 8'h5A; tick(); write_enb = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            nchk++; if (soft_reset !== 1'b0 || vld_out !== 1'b1) begin
                nerr++; $display("FAIL wd_early[%0d]: soft=%b vld=%b want soft=0 vld=1", i, soft_reset, vld_out);
            end
        end
        // Write in the flush cycle must be dropped.
        write_enb = 1'b1; data_in = 8'h99; tick(); write_enb = 1'b0;
        nchk++; if (soft_reset !== 1'b1) begin nerr++; $display("FAIL wd_pulse: got %b want 1", soft_reset); end
        nchk++; if (vld_out !== 1'b0) begin nerr++; $display("FAIL wd_vld: got %b want 0", vld_out); end
        nchk++; if (data_out !== 8'h00) begin nerr++; $display("FAIL wd_dout: got %h want 00", data_out); end
        tick();
        nchk++; if (soft_reset !== 1'b0) begin nerr++; $display("FAIL wd_one_cycle: got %b want 0", soft_reset); end
        nchk++; if (empty !== 1'b1) begin nerr++; $display("FAIL wd_flush_write: empty %b want 1", empty); end
        write_enb = 1'b1; data_in = 8'h3C; tick(); write_enb = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        read_enb = 1'b1; tick(); read_enb = 1'b0;
        nchk++; if (soft_reset !== 1'b0) begin nerr++; $display("FAIL wd_save_soft: got %b want 0", soft_reset); end
        nchk++; if (data_out !== 8'h3C) begin nerr++; $display("FAIL wd_save_data: got %h want 3c", data_out); end
        nchk++; if (dut.u_wdog.wd_cnt_q !== 5'd0) begin nerr++; $display("FAIL wd_save_cnt: got %0d want 0", dut.u_wdog.wd_cnt_q); end
        for (int i = 0; i < 3; i++) begin
            tick();
            nchk++; if (soft_reset !== 1'b0) begin nerr++; $display("FAIL wd_quiet[%0d]: got %b want 0", i, soft_reset); end
        end
    endtask

    task automatic test_random();
        int rd_pct = 50;
        int wr_pct = 50;
        int seen_soft = 0;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) begin
                rd_pct = (c % 200 == 100) ? 0 : int'($urandom_range(10, 90));
                wr_pct = int'($urandom_range(20, 90));
            end
            write_enb = ($urandom_range(0, 99) < wr_pct);
            read_enb  = ($urandom_range(0, 99) < rd_pct);
            data_in   = 8'($urandom);
            lfd_state = ($urandom_range(0, 4) == 0);
            tick();
            if (m_soft) seen_soft++;
            nchk++; if (data_out !== m_dout) begin nerr++; $display("FAIL rnd_dout[%0d]: got %h want %h", c, data_out, m_dout); end
            nchk++; if (empty !== (q.size() == 0) || vld_out !== (q.size() != 0)) begin
                nerr++; $display("FAIL rnd_empty[%0d]: empty=%b vld=%b occ_want=%0d", c, empty, vld_out, q.size());
            end
            nchk++; if (full !== (q.size() == DEPTH)) begin nerr++; $display("FAIL rnd_full[%0d]: got %b occ_want=%0d", c, full, q.size()); end
            nchk++; if (soft_reset !== m_soft) begin nerr++; $display("FAIL rnd_soft[%0d]: got %b want %b", c, soft_reset, m_soft); end
            nchk++; if (int'(dut.pkt_cnt_q) !== m_pkt) begin nerr++; $display("FAIL rnd_pkt[%0d]: got %0d want %0d", c, dut.pkt_cnt_q, m_pkt); end
        end
        write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0;
        nchk++; if (seen_soft == 0) begin nerr++; $display("FAIL rnd_wd_cover: no watchdog expiry observed"); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_full();
        test_back_to_back();
        test_watchdog();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
